// File: rtl/aoi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aoi_arbiter
// Description : Round-robin arbiter sharing one registered (a&b)|(c&d)
//               evaluator among four requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module aoi_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [15:0]      ops,
    output logic [3:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic [1:0]       res_id,
    output logic [CNT_W-1:0] ops_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [3:0]       r_gnt;
    logic             r_a, r_b, r_c, r_d, r_f;
    logic             r_done;
    logic             r_result;
    logic [1:0]       r_res_id;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_found;
    logic [3:0]       w_slice;

    // Search starts just after the last winner, so it ends at lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_slice = ops[{w_win, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd3;
            r_gnt    <= 4'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_c      <= 1'b0;
            r_d      <= 1'b0;
            r_f      <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
            r_res_id <= 2'd0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt   <= 4'b0001 << w_win;
                        r_ptr   <= w_win;
                        r_a     <= w_slice[3];
                        r_b     <= w_slice[2];
                        r_c     <= w_slice[1];
                        r_d     <= w_slice[0];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_f     <= (r_a & r_b) | (r_c & r_d);
                    r_state <= EVAL;
                end
                EVAL: begin
                    r_done   <= 1'b1;
                    r_result <= r_f;
                    r_res_id <= r_ptr;
                    r_cnt    <= r_cnt + 1'b1;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_done  <= 1'b0;
                    r_gnt   <= 4'd0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign result  = r_result;
    assign res_id  = r_res_id;
    assign ops_cnt = r_cnt;

endmodule
`default_nettype wire
